// File: rtl/eth_reset_sequencer.sv
// rtl/eth_reset_sequencer.sv - ordered per-stage reset release with ready timeout and soft re-sequence
// Optional: ETH_RST_SEQ_MONITOR_EN adds ready_i loss detection while in DONE.
module eth_reset_sequencer #(
    parameter int num_stages_p     = 3,
    parameter int hold_cycles_p    = 16,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [num_stages_p-1:0] ready_i,
    input  logic                    soft_reset_v_i,
    output logic                    soft_reset_ready_and_o,
    output logic [num_stages_p-1:0] reset_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [((num_stages_p > 1) ? $clog2(num_stages_p) : 1)-1:0] stage_o
);

    localparam int sw_lp = (num_stages_p > 1) ? $clog2(num_stages_p) : 1;
    localparam int hw_lp = (hold_cycles_p > 1) ? $clog2(hold_cycles_p) : 1;
    localparam int tw_lp = $clog2(timeout_cycles_p);

    localparam logic [hw_lp-1:0] hold_last_lp    = hw_lp'(hold_cycles_p - 1);
    localparam logic [tw_lp-1:0] timeout_last_lp = tw_lp'(timeout_cycles_p - 1);
    localparam logic [sw_lp-1:0] stage_last_lp   = sw_lp'(num_stages_p - 1);

    typedef enum logic [2:0] {
        S_ASSERT,
        S_RELEASE,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state_r, state_n;
    logic [hw_lp-1:0]         hold_r, hold_n;
    logic [tw_lp-1:0]         timer_r, timer_n;
    logic [sw_lp-1:0]         idx_r, idx_n;
    logic [num_stages_p-1:0]  rst_r, rst_n;
`ifdef ETH_RST_SEQ_MONITOR_EN
    logic [num_stages_p-1:0]  low_r, low_n;
    logic [num_stages_p-1:0]  lost;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= S_ASSERT;
            hold_r  <= '0;
            timer_r <= '0;
            idx_r   <= '0;
            rst_r   <= '1;
`ifdef ETH_RST_SEQ_MONITOR_EN
            low_r   <= '0;
`endif
        end else begin
            state_r <= state_n;
            hold_r  <= hold_n;
            timer_r <= timer_n;
            idx_r   <= idx_n;
            rst_r   <= rst_n;
`ifdef ETH_RST_SEQ_MONITOR_EN
            low_r   <= low_n;
`endif
        end
    end

    always_comb begin
        state_n = state_r;
        hold_n  = hold_r;
        timer_n = timer_r;
        idx_n   = idx_r;
        rst_n   = rst_r;
`ifdef ETH_RST_SEQ_MONITOR_EN
        low_n   = '0;
        lost    = '0;
`endif
        case (state_r)
            S_ASSERT: begin
                hold_n = hold_r + 1'b1;
                if (hold_r == hold_last_lp) begin
                    state_n = S_RELEASE;
                    idx_n   = '0;
                end
            end
            S_RELEASE: begin
                rst_n[idx_r] = 1'b0;
                timer_n      = '0;
                state_n      = S_WAIT;
            end
            S_WAIT: begin
                if (ready_i[idx_r]) begin
                    if (idx_r == stage_last_lp) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n   = idx_r + 1'b1;
                        state_n = S_RELEASE;
                    end
                end else if (timer_r == timeout_last_lp) begin
                    state_n = S_ERROR;
                    rst_n   = '1;
                end else begin
                    timer_n = timer_r + 1'b1;
                end
            end
            S_DONE: begin
                rst_n = '0;
`ifdef ETH_RST_SEQ_MONITOR_EN
                // a stage counts as lost only when its ready is low on two consecutive samples
                low_n = ~ready_i;
                lost  = low_r & ~ready_i;
                if (|lost) begin
                    state_n = S_ERROR;
                    rst_n   = '1;
                    for (int i = num_stages_p - 1; i >= 0; i--) begin
                        if (lost[i]) idx_n = sw_lp'(i);
                    end
                end
`endif
            end
            S_ERROR: begin
                rst_n = '1;
            end
            default: begin
                state_n = S_ASSERT;
                hold_n  = '0;
                idx_n   = '0;
                rst_n   = '1;
            end
        endcase

        if (soft_reset_v_i && (state_r == S_DONE || state_r == S_ERROR)) begin
            state_n = S_ASSERT;
            hold_n  = '0;
            timer_n = '0;
            idx_n   = '0;
            rst_n   = '1;
`ifdef ETH_RST_SEQ_MONITOR_EN
            low_n   = '0;
`endif
        end
    end

    assign reset_o                = rst_r;
    assign done_o                 = (state_r == S_DONE);
    assign error_o                = (state_r == S_ERROR);
    assign soft_reset_ready_and_o = (state_r == S_DONE) || (state_r == S_ERROR);
    assign stage_o                = idx_r;

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// tb/tb_eth_reset_sequencer.sv - directed checks of reset ordering, timeout, soft and hard restart
module tb_eth_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rdy_a = 3'b111;
    logic       sv_a  = 1'b0;
    logic       srdy_a;
    logic [2:0] ro_a;
    logic       done_a, err_a;
    logic [1:0] stg_a;

    logic [2:0] rdy_b = 3'b111;
    logic       sv_b  = 1'b0;
    logic       srdy_b;
    logic [2:0] ro_b;
    logic       done_b, err_b;
    logic [1:0] stg_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    eth_reset_sequencer u_dut (
        .clk_i                  (clk),
        .reset_i                (rst),
        .ready_i                (rdy_a),
        .soft_reset_v_i         (sv_a),
        .soft_reset_ready_and_o (srdy_a),
        .reset_o                (ro_a),
        .done_o                 (done_a),
        .error_o                (err_a),
        .stage_o                (stg_a)
    );

    eth_reset_sequencer #(.timeout_cycles_p(8)) u_to (
        .clk_i                  (clk),
        .reset_i                (rst),
        .ready_i                (rdy_b),
        .soft_reset_v_i         (sv_b),
        .soft_reset_ready_and_o (srdy_b),
        .reset_o                (ro_b),
        .done_o                 (done_b),
        .error_o                (err_b),
        .stage_o                (stg_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // nominal sequence, soft request ignored mid-sequence
        hard_reset();
        check("rst_reset_o", 32'(ro_a), 32'h7);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_error", 32'(err_a), 32'h0);
        check("rst_stage", 32'(stg_a), 32'h0);
        run_to(5);
        check("busy_srdy", 32'(srdy_a), 32'h0);
        sv_a = 1'b1;
        tick();
        sv_a = 1'b0;
        run_to(16);
        check("nom_c16", 32'(ro_a), 32'h7);
        run_to(17);
        check("nom_c17", 32'(ro_a), 32'h6);
        run_to(18);
        check("nom_c18", 32'(ro_a), 32'h6);
        run_to(19);
        check("nom_c19", 32'(ro_a), 32'h4);
        run_to(21);
        check("nom_c21", 32'(ro_a), 32'h0);
        check("nom_c21_done", 32'(done_a), 32'h0);
        run_to(22);
        check("nom_c22_done", 32'(done_a), 32'h1);
        check("nom_c22_srdy", 32'(srdy_a), 32'h1);

        // stage 1 ready delayed
        rdy_a = 3'b101;
        hard_reset();
        run_to(19);
        check("slow_c19", 32'(ro_a), 32'h4);
        run_to(40);
        check("slow_c40", 32'(ro_a), 32'h4);
        check("slow_c40_stage", 32'(stg_a), 32'h1);
        run_to(41);
        rdy_a = 3'b111;
        run_to(42);
        check("slow_c42", 32'(ro_a), 32'h4);
        run_to(43);
        check("slow_c43", 32'(ro_a), 32'h0);
        check("slow_c43_done", 32'(done_a), 32'h0);
        run_to(44);
        check("slow_c44_done", 32'(done_a), 32'h1);

        // timeout then soft re-sequence
        rdy_b = 3'b101;
        hard_reset();
        run_to(26);
        check("to_c26_err", 32'(err_b), 32'h0);
        run_to(27);
        check("to_c27_err", 32'(err_b), 32'h1);
        check("to_c27_reset", 32'(ro_b), 32'h7);
        check("to_c27_stage", 32'(stg_b), 32'h1);
        check("to_c27_srdy", 32'(srdy_b), 32'h1);
        check("to_c27_done", 32'(done_b), 32'h0);
        rdy_b = 3'b111;
        sv_b  = 1'b1;
        tick();
        sv_b  = 1'b0;
        cyc   = 0;
        check("soft_err", 32'(err_b), 32'h0);
        check("soft_reset", 32'(ro_b), 32'h7);
        check("soft_stage", 32'(stg_b), 32'h0);
        run_to(16);
        check("soft_c16", 32'(ro_b), 32'h7);
        run_to(17);
        check("soft_c17", 32'(ro_b), 32'h6);
        run_to(19);
        check("soft_c19", 32'(ro_b), 32'h4);
        run_to(21);
        check("soft_c21", 32'(ro_b), 32'h0);
        run_to(22);
        check("soft_c22_done", 32'(done_b), 32'h1);

        // hard reset during WAIT of stage 1
        rdy_a = 3'b101;
        hard_reset();
        run_to(25);
        check("mid_stage", 32'(stg_a), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_reset_o", 32'(ro_a), 32'h7);
        check("mid_stage0", 32'(stg_a), 32'h0);
        check("mid_done", 32'(done_a), 32'h0);
        rst   = 1'b0;
        rdy_a = 3'b111;
        cyc   = 0;
        run_to(16);
        check("mid_c16", 32'(ro_a), 32'h7);
        run_to(17);
        check("mid_c17", 32'(ro_a), 32'h6);
        run_to(22);
        check("mid_c22_done", 32'(done_a), 32'h1);

        // ready loss while in DONE
        rdy_a = 3'b011;
        tick();
        rdy_a = 3'b111;
        tick();
        tick();
        check("glitch1_done", 32'(done_a), 32'h1);
        check("glitch1_reset", 32'(ro_a), 32'h0);
        rdy_a = 3'b011;
        tick();
        tick();
        rdy_a = 3'b111;
        tick();
`ifdef ETH_RST_SEQ_MONITOR_EN
        check("lost_err", 32'(err_a), 32'h1);
        check("lost_done", 32'(done_a), 32'h0);
        check("lost_stage", 32'(stg_a), 32'h2);
        check("lost_reset", 32'(ro_a), 32'h7);
`else
        check("lost_err", 32'(err_a), 32'h0);
        check("lost_done", 32'(done_a), 32'h1);
        check("lost_stage", 32'(stg_a), 32'h2);
        check("lost_reset", 32'(ro_a), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
